lcd_char_writer: RTL and testbench

- Character-LCD interface stage on the Spartan-3E board, 4-bit mode, 50 MHz clock.
- Sits directly downstream of the adder/display logic.
- Runs the HD44780 power-on init and function-set sequence once after reset.
- Then accepts one byte per valid/ready handshake (command or data) and serialises it as two timed nibbles with the correct E pulse and busy wait.

---
 rtl/lcd_char_writer_if.sv | 10 +
 rtl/lcd_char_writer.sv | 147 ++++++++++++++
 tb/tb_lcd_char_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_char_writer_if.sv
// Byte write handshake between the adder/display logic and the LCD writer.
interface lcd_char_writer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;

    modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 4-bit character LCD writer: power-on init, then one byte per handshake as two timed nibbles.
// Optional build macro LCD_HEX_EN: data bytes 0x00-0x0F are sent as their ASCII hex digit.
module lcd_char_writer #(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_SHORT   = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_EPULSE  = 12,
    parameter int unsigned T_NIBGAP  = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_char_writer_if.slave   wr,
    output logic               init_done,
    output logic               sf_e,
    output logic               lcd_e,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic [3:0]         lcd_data
);

    typedef enum logic [3:0] {
        PWRUP, INIT_NIB, INIT_BYTE, IDLE,
        SETUP_HI, EHI_HI, HOLD_HI, GAP,
        SETUP_LO, EHI_LO, HOLD_LO, BUSY
    } state_t;

    state_t      state;
    logic [19:0] cnt;
    logic [3:0]  init_step;
    logic [7:0]  byte_q;
    logic [7:0]  acc_byte;
    logic [7:0]  init_byte;
    logic [19:0] busy_load;

    // A state lasting t cycles loads t-1 and leaves when the counter reads 0.
    function automatic logic [19:0] load_val(input int unsigned t);
        return 20'(t - 1);
    endfunction

    always_comb begin
        acc_byte = wr.wr_data;
`ifdef LCD_HEX_EN
        if (wr.wr_rs && wr.wr_data[7:4] == 4'h0)
            acc_byte = (wr.wr_data[3:0] < 4'd10) ? (8'h30 + wr.wr_data) : (8'h37 + wr.wr_data);
`endif
    end

    always_comb begin
        unique case (init_step)
            4'd4:    init_byte = 8'h28;
            4'd5:    init_byte = 8'h06;
            4'd6:    init_byte = 8'h0C;
            default: init_byte = 8'h01;
        endcase
    end

    // Steps 0..3 are the bare init nibbles; later transfers pick the wait from the byte itself.
    always_comb begin
        busy_load = load_val(T_SHORT);
        if (init_step == 4'd0)
            busy_load = load_val(T_INIT1);
        else if (init_step == 4'd1)
            busy_load = load_val(T_INIT2);
        else if (init_step >= 4'd4 && !lcd_rs && (byte_q == 8'h01 || byte_q == 8'h02))
            busy_load = load_val(T_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= PWRUP;
            cnt         <= load_val(T_POWERUP);
            init_step   <= '0;
            byte_q      <= '0;
            wr.wr_ready <= 1'b0;
            init_done   <= 1'b0;
            sf_e        <= 1'b1;
            lcd_e       <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_data    <= '0;
        end else begin
            sf_e   <= 1'b1;
            lcd_rw <= 1'b0;
            if (cnt != '0)
                cnt <= cnt - 20'd1;
            unique case (state)
                PWRUP:
                    if (cnt == '0) state <= INIT_NIB;
                INIT_NIB: begin
                    lcd_data <= (init_step == 4'd3) ? 4'h2 : 4'h3;
                    lcd_rs   <= 1'b0;
                    cnt      <= load_val(2);
                    state    <= SETUP_LO;
                end
                INIT_BYTE: begin
                    byte_q   <= init_byte;
                    lcd_data <= init_byte[7:4];
                    lcd_rs   <= 1'b0;
                    cnt      <= load_val(2);
                    state    <= SETUP_HI;
                end
                IDLE: begin
                    // Ready is raised one cycle after entering IDLE, so acceptance uses the registered flag.
                    wr.wr_ready <= 1'b1;
                    init_done   <= 1'b1;
                    if (wr.wr_ready && wr.wr_valid) begin
                        byte_q      <= acc_byte;
                        lcd_data    <= acc_byte[7:4];
                        lcd_rs      <= wr.wr_rs;
                        wr.wr_ready <= 1'b0;
                        cnt         <= load_val(2);
                        state       <= SETUP_HI;
                    end
                end
                SETUP_HI:
                    if (cnt == '0) begin lcd_e <= 1'b1; cnt <= load_val(T_EPULSE); state <= EHI_HI; end
                EHI_HI:
                    if (cnt == '0) begin lcd_e <= 1'b0; cnt <= load_val(1); state <= HOLD_HI; end
                HOLD_HI:
                    if (cnt == '0) begin cnt <= load_val(T_NIBGAP); state <= GAP; end
                GAP:
                    if (cnt == '0) begin lcd_data <= byte_q[3:0]; cnt <= load_val(2); state <= SETUP_LO; end
                SETUP_LO:
                    if (cnt == '0) begin lcd_e <= 1'b1; cnt <= load_val(T_EPULSE); state <= EHI_LO; end
                EHI_LO:
                    if (cnt == '0) begin lcd_e <= 1'b0; cnt <= load_val(1); state <= HOLD_LO; end
                HOLD_LO:
                    if (cnt == '0) begin cnt <= busy_load; state <= BUSY; end
                BUSY:
                    if (cnt == '0) begin
                        if (init_step < 4'd7) begin
                            init_step <= init_step + 4'd1;
                            state     <= (init_step < 4'd3) ? INIT_NIB : INIT_BYTE;
                        end else begin
                            init_step <= 4'd8;
                            state     <= IDLE;
                        end
                    end
                default:
                    state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with shortened timing parameters.
module tb_lcd_char_writer;
    localparam int unsigned P_PU = 100, P_I1 = 40, P_I2 = 20, P_SH = 10;
    localparam int unsigned P_CL = 30, P_EP = 3, P_GAP = 5;
    localparam int N_VEC = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done, sf_e, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_data;

    lcd_char_writer_if bus();

    lcd_char_writer #(
        .T_POWERUP(P_PU), .T_INIT1(P_I1), .T_INIT2(P_I2), .T_SHORT(P_SH),
        .T_CLEAR(P_CL), .T_EPULSE(P_EP), .T_NIBGAP(P_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(bus), .init_done(init_done), .sf_e(sf_e),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Bus monitor: records {rs, nibble} on each E rise and checks pulse width.
    logic [4:0] nq[$];
    logic       e_prev = 1'b0;
    bit         mon_en = 1'b0;
    int         ehi_len = 0, pulse_bad = 0, static_bad = 0, since_fall = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sf_e !== 1'b1 || lcd_rw !== 1'b0) static_bad++;
            if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
                nq.push_back({lcd_rs, lcd_data});
                ehi_len = 1;
                since_fall++;
            end else if (lcd_e === 1'b1) begin
                ehi_len++;
                since_fall++;
            end else if (e_prev === 1'b1) begin
                if (rst_n && ehi_len != int'(P_EP)) pulse_bad++;
                since_fall = 1;
            end else begin
                since_fall++;
            end
            e_prev = lcd_e;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_init();
        logic [3:0] init_exp [12];
        int idle, n;
        bit ready_early;
        init_exp = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        rst_n = 1'b0;
        repeat (3) step();
        mon_en = 1'b1;
        nq.delete();
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_data", lcd_data, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        rst_n = 1'b1;
        idle = 0;
        while (lcd_e === 1'b0 && idle < 300) begin idle++; step(); end
        chk("powerup_idle_window", int'(idle >= int'(P_PU) && idle <= int'(P_PU) + 5), 1);
        n = 0;
        ready_early = 1'b0;
        while (init_done !== 1'b1 && n < 3000) begin
            if (bus.wr_ready === 1'b1) ready_early = 1'b1;
            step();
            n++;
        end
        chk("init_done_rise", init_done, 1);
        chk("ready_with_done", bus.wr_ready, 1);
        chk("ready_before_done", ready_early, 0);
        // E fall, 1 hold cycle, T_CLEAR busy, 1 cycle before ready.
        chk("done_after_clear_wait", since_fall, 1 + 1 + int'(P_CL) + 1);
        chk("init_nib_count", nq.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < nq.size()) chk($sformatf("init_nib%0d", i), nq[i], {1'b0, init_exp[i]});
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.wr_ready !== 1'b1 && n < 500) begin step(); n++; end
        chk({name, "_ready_timeout"}, bus.wr_ready, 1);
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [3:0] hi;
        logic [3:0] lo;
        int         low;
    } vec_t;

    initial begin
        vec_t vt [N_VEC];
        int low;
        vt[0] = '{1'b1, 8'h41, 4'h4, 4'h1, 28};
        vt[1] = '{1'b0, 8'h01, 4'h0, 4'h1, 48};
        vt[2] = '{1'b0, 8'h02, 4'h0, 4'h2, 48};
`ifdef LCD_HEX_EN
        vt[3] = '{1'b1, 8'h0C, 4'h4, 4'h3, 28};
        vt[4] = '{1'b1, 8'h07, 4'h3, 4'h7, 28};
        vt[6] = '{1'b1, 8'h01, 4'h3, 4'h1, 28};
`else
        vt[3] = '{1'b1, 8'h0C, 4'h0, 4'hC, 28};
        vt[4] = '{1'b1, 8'h07, 4'h0, 4'h7, 28};
        vt[6] = '{1'b1, 8'h01, 4'h0, 4'h1, 28};
`endif
        vt[5] = '{1'b0, 8'h0C, 4'h0, 4'hC, 28};
        vt[7] = '{1'b0, 8'h80, 4'h8, 4'h0, 28};
        vt[8] = '{1'b1, 8'h48, 4'h4, 4'h8, 28};

        bus.wr_valid = 1'b0;
        bus.wr_rs    = 1'b0;
        bus.wr_data  = '0;

        run_init();

        for (int i = 0; i < N_VEC; i++) begin
            wait_ready($sformatf("v%0d", i));
            nq.delete();
            bus.wr_valid = 1'b1;
            bus.wr_rs    = vt[i].rs;
            bus.wr_data  = vt[i].data;
            step();
            bus.wr_valid = 1'b0;
            low = 0;
            while (bus.wr_ready !== 1'b1 && low < 500) begin low++; step(); end
            chk($sformatf("v%0d_ready_low", i), low, vt[i].low);
            chk($sformatf("v%0d_nib_count", i), nq.size(), 2);
            if (nq.size() >= 1) chk($sformatf("v%0d_hi", i), nq[0], {vt[i].rs, vt[i].hi});
            if (nq.size() >= 2) chk($sformatf("v%0d_lo", i), nq[1], {vt[i].rs, vt[i].lo});
        end

        // Back-to-back: valid held high, second byte only taken once ready returns.
        nq.delete();
        bus.wr_valid = 1'b1;
        bus.wr_rs    = 1'b1;
        bus.wr_data  = 8'h48;
        wait_ready("b2b_a");
        step();
        chk("b2b_ready_drop", bus.wr_ready, 0);
        bus.wr_data = 8'h49;
        wait_ready("b2b_b");
        step();
        bus.wr_valid = 1'b0;
        wait_ready("b2b_c");
        chk("b2b_nib_count", nq.size(), 4);
        if (nq.size() == 4) begin
            chk("b2b_nib0", nq[0], 5'h14);
            chk("b2b_nib1", nq[1], 5'h18);
            chk("b2b_nib2", nq[2], 5'h14);
            chk("b2b_nib3", nq[3], 5'h19);
        end

        // Reset during E high of a data upper nibble.
        nq.delete();
        bus.wr_valid = 1'b1;
        bus.wr_rs    = 1'b1;
        bus.wr_data  = 8'h41;
        step();
        bus.wr_valid = 1'b0;
        low = 0;
        while (lcd_e !== 1'b1 && low < 100) begin low++; step(); end
        chk("abort_reached_ehi", lcd_e, 1);
        rst_n = 1'b0;
        step();
        chk("abort_lcd_e", lcd_e, 0);
        chk("abort_wr_ready", bus.wr_ready, 0);
        chk("abort_init_done", init_done, 0);
        run_init();

        chk("ehi_pulse_len_errors", pulse_bad, 0);
        chk("sf_e_rw_errors", static_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
